// File: rtl/wta_scheduler.sv
// Winner-take-all scheduler for six neuron potentials.
// A collection window gathers potentials, one compare cycle picks the
// largest (lowest index on ties), and the winner is offered downstream with
// a valid/ready handshake, followed by a refractory hold-off period.
module wta_scheduler #(
  parameter int p_width  = 19,
  parameter int p_window = 16,
  parameter int p_refr   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [5:0]            i_valid,
  input  logic [6*p_width-1:0]  i_pot,
  input  logic [p_width-1:0]    i_thresh,
  input  logic                  i_win_ready,
  output logic                  o_win_valid,
  output logic [5:0]            o_win_index,
  output logic [p_width-1:0]    o_win_value,
  output logic                  o_no_winner,
  output logic                  o_busy
);

  localparam int WW = (p_window > 1) ? $clog2(p_window) : 1;
  localparam int RW = (p_refr > 1) ? $clog2(p_refr) : 1;
  localparam logic [WW-1:0] L_WIN_LOAD  = WW'(p_window - 1);
  localparam logic [RW-1:0] L_REFR_LOAD = RW'((p_refr > 0) ? (p_refr - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_COMPARE,
    S_ISSUE,
    S_REFRACT
  } state_t;

  state_t               r_state;
  logic [p_width-1:0]   r_pot [6];
  logic [5:0]           r_seen;
  logic [WW-1:0]        r_win_cnt;
  logic [RW-1:0]        r_ref_cnt;
  logic                 r_win_valid;
  logic [5:0]           r_win_index;
  logic [p_width-1:0]   r_win_value;
  logic                 r_no_winner;

  logic [5:0]           w_seen_nxt;
  logic [p_width-1:0]   w_max01, w_max23, w_max45, w_max03, w_max;
  logic [5:0]           w_idx01, w_idx23, w_idx45, w_idx03, w_idx;
  logic                 w_no_win;

  assign w_seen_nxt = r_seen | i_valid;

  // Pairwise max tree; the left operand wins on equality so the lowest index wins ties.
  always_comb begin
    w_max01 = r_pot[0];
    w_idx01 = 6'b000001;
    if (r_pot[1] > r_pot[0]) begin
      w_max01 = r_pot[1];
      w_idx01 = 6'b000010;
    end
    w_max23 = r_pot[2];
    w_idx23 = 6'b000100;
    if (r_pot[3] > r_pot[2]) begin
      w_max23 = r_pot[3];
      w_idx23 = 6'b001000;
    end
    w_max45 = r_pot[4];
    w_idx45 = 6'b010000;
    if (r_pot[5] > r_pot[4]) begin
      w_max45 = r_pot[5];
      w_idx45 = 6'b100000;
    end
    w_max03 = w_max01;
    w_idx03 = w_idx01;
    if (w_max23 > w_max01) begin
      w_max03 = w_max23;
      w_idx03 = w_idx23;
    end
    w_max = w_max03;
    w_idx = w_idx03;
    if (w_max45 > w_max03) begin
      w_max = w_max45;
      w_idx = w_idx45;
    end
  end

  // An all-zero field never wins, even against a zero threshold.
  assign w_no_win = (w_max == '0) || (w_max < i_thresh);

  // Scheduler FSM with registered winner/no-winner outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < 6; k++) r_pot[k] <= '0;
      r_seen      <= '0;
      r_win_cnt   <= '0;
      r_ref_cnt   <= '0;
      r_win_valid <= 1'b0;
      r_win_index <= '0;
      r_win_value <= '0;
      r_no_winner <= 1'b0;
    end else begin
      r_no_winner <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < 6; k++) r_pot[k] <= '0;
            r_seen    <= '0;
            r_win_cnt <= L_WIN_LOAD;
            r_state   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          for (int k = 0; k < 6; k++) begin
            if (i_valid[k]) r_pot[k] <= i_pot[k*p_width +: p_width];
          end
          r_seen <= w_seen_nxt;
          if ((&w_seen_nxt) || (r_win_cnt == '0)) begin
            r_state <= S_COMPARE;
          end else begin
            r_win_cnt <= r_win_cnt - WW'(1);
          end
        end
        S_COMPARE: begin
          if (w_no_win) begin
            r_no_winner <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_win_valid <= 1'b1;
            r_win_index <= w_idx;
            r_win_value <= w_max;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_win_ready) begin
            r_win_valid <= 1'b0;
            r_win_index <= '0;
            r_win_value <= '0;
            if (p_refr == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_ref_cnt <= L_REFR_LOAD;
              r_state   <= S_REFRACT;
            end
          end
        end
        S_REFRACT: begin
          if (r_ref_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_ref_cnt <= r_ref_cnt - RW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_win_valid = r_win_valid;
  assign o_win_index = r_win_index;
  assign o_win_value = r_win_value;
  assign o_no_winner = r_no_winner;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_wta_scheduler.sv
// Directed testbench for wta_scheduler with default parameters.
module tb_wta_scheduler;

  localparam int W = 19;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic [5:0]        i_valid;
  logic [6*W-1:0]    i_pot;
  logic [W-1:0]      i_thresh;
  logic              i_win_ready;
  logic              o_win_valid;
  logic [5:0]        o_win_index;
  logic [W-1:0]      o_win_value;
  logic              o_no_winner;
  logic              o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  wta_scheduler #(.p_width(W), .p_window(16), .p_refr(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .i_pot       (i_pot),
    .i_thresh    (i_thresh),
    .i_win_ready (i_win_ready),
    .o_win_valid (o_win_valid),
    .o_win_index (o_win_index),
    .o_win_value (o_win_value),
    .o_no_winner (o_no_winner),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_pots(input logic [W-1:0] p0, input logic [W-1:0] p1,
                          input logic [W-1:0] p2, input logic [W-1:0] p3,
                          input logic [W-1:0] p4, input logic [W-1:0] p5);
    i_pot = {p5, p4, p3, p2, p1, p0};
  endtask

  // Pulse start from IDLE and land in the first COLLECT cycle.
  task automatic do_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_valid     = '0;
    i_pot       = '0;
    i_thresh    = '0;
    i_win_ready = 1'b0;
    step();
    step();
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_valid", 32'(o_win_valid), 32'h0);
    chk("rst_index", 32'(o_win_index), 32'h0);
    chk("rst_value", 32'(o_win_value), 32'h0);
    chk("rst_nowin", 32'(o_no_winner), 32'h0);
    i_rst_n = 1'b1;
    step();

    // All six in one cycle, tie 9/9 goes to neuron 1.
    do_start();
    chk("t1_busy", 32'(o_busy), 32'h1);
    set_pots(5, 9, 3, 9, 1, 2);
    i_thresh = 4;
    i_valid  = 6'h3F;
    step();
    i_valid = '0;
    chk("t1_cmp_valid", 32'(o_win_valid), 32'h0);
    step();
    chk("t1_valid", 32'(o_win_valid), 32'h1);
    chk("t1_index", 32'(o_win_index), 32'h02);
    chk("t1_value", 32'(o_win_value), 32'd9);
    chk("t1_nowin", 32'(o_no_winner), 32'h0);

    // Backpressure for five cycles: outputs hold.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(o_win_valid), 32'h1);
      chk("t2_hold_index", 32'(o_win_index), 32'h02);
      chk("t2_hold_value", 32'(o_win_value), 32'd9);
    end
    i_win_ready = 1'b1;
    step();
    i_win_ready = 1'b0;
    chk("t2_xfer_valid", 32'(o_win_valid), 32'h0);
    chk("t2_xfer_index", 32'(o_win_index), 32'h0);
    chk("t2_xfer_value", 32'(o_win_value), 32'h0);
    // Eight refractory cycles; a start in the middle is dropped.
    for (int i = 0; i < 8; i++) begin
      chk("t2_refr_busy", 32'(o_busy), 32'h1);
      i_start = (i == 3);
      step();
    end
    i_start = 1'b0;
    chk("t2_idle_busy", 32'(o_busy), 32'h0);
    step();
    chk("t2_not_queued", 32'(o_busy), 32'h0);

    // Single strobe: window runs to its full 16 cycles.
    do_start();
    set_pots(0, 0, 0, 0, 7, 0);
    i_thresh = 0;
    i_valid  = 6'b010000;
    step();
    i_valid = '0;
    for (int i = 1; i < 16; i++) step();
    chk("t3_compare_valid", 32'(o_win_valid), 32'h0);
    chk("t3_compare_busy",  32'(o_busy), 32'h1);
    step();
    chk("t3_valid", 32'(o_win_valid), 32'h1);
    chk("t3_index", 32'(o_win_index), 32'h10);
    chk("t3_value", 32'(o_win_value), 32'd7);
    i_win_ready = 1'b1;
    step();
    i_win_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t3_idle", 32'(o_busy), 32'h0);

    // Max below threshold: no-winner pulse.
    do_start();
    set_pots(1, 3, 0, 2, 3, 1);
    i_thresh = 4;
    i_valid  = 6'h3F;
    step();
    i_valid = '0;
    chk("t4_cmp_nowin", 32'(o_no_winner), 32'h0);
    step();
    chk("t4_nowin", 32'(o_no_winner), 32'h1);
    chk("t4_valid", 32'(o_win_valid), 32'h0);
    chk("t4_busy",  32'(o_busy), 32'h0);
    step();
    chk("t4_pulse_end", 32'(o_no_winner), 32'h0);

    // All zero with zero threshold still yields no winner.
    do_start();
    set_pots(0, 0, 0, 0, 0, 0);
    i_thresh = 0;
    i_valid  = 6'h3F;
    step();
    i_valid = '0;
    step();
    chk("t5_nowin", 32'(o_no_winner), 32'h1);
    chk("t5_valid", 32'(o_win_valid), 32'h0);

    // Last strobe wins; tie across groups; max equal to threshold wins.
    do_start();
    set_pots(20, 0, 0, 0, 0, 0);
    i_thresh = 8;
    i_valid  = 6'b000001;
    step();
    set_pots(1, 2, 3, 8, 0, 8);
    i_valid = 6'h3F;
    step();
    i_valid = '0;
    step();
    chk("t6_valid", 32'(o_win_valid), 32'h1);
    chk("t6_index", 32'(o_win_index), 32'h08);
    chk("t6_value", 32'(o_win_value), 32'd8);

    // Asynchronous reset while the winner is offered.
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t7_valid", 32'(o_win_valid), 32'h0);
    chk("t7_busy",  32'(o_busy), 32'h0);
    chk("t7_index", 32'(o_win_index), 32'h0);
    chk("t7_value", 32'(o_win_value), 32'h0);
    #2;
    i_rst_n = 1'b1;
    step();

    // First window after reset; full-scale potential on neuron 5.
    do_start();
    chk("t8_busy", 32'(o_busy), 32'h1);
    set_pots(0, 0, 0, 0, 0, 19'h7FFFF);
    i_thresh = 0;
    i_valid  = 6'h3F;
    step();
    i_valid = '0;
    step();
    chk("t8_valid", 32'(o_win_valid), 32'h1);
    chk("t8_index", 32'(o_win_index), 32'h20);
    chk("t8_value", 32'(o_win_value), 32'h7FFFF);
    i_win_ready = 1'b1;
    step();
    i_win_ready = 1'b0;
    chk("t8_xfer_valid", 32'(o_win_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wta_scheduler.md
WTA_SCHEDULER -- requirements
Module: wta_scheduler

Interface
REQ-001 SHALL have parameter p_width, default 19, potential bit width.
REQ-002 SHALL have parameter p_window, default 16, maximum COLLECT cycles (>=1).
REQ-003 SHALL have parameter p_refr, default 8, refractory cycles after a winner transfer (0 allowed).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_start  input  1  begins a collection window.
REQ-007 SHALL have port i_valid  input  6  per-neuron potential strobe; bit k qualifies slice k of i_pot.
REQ-008 SHALL have port i_pot  input  6*p_width  packed potentials; slice k = bits [k*p_width +: p_width].
REQ-009 SHALL have port i_thresh  input  p_width  minimum winning potential, sampled in COMPARE.
REQ-010 SHALL have port i_win_ready  input  1  downstream accepts winner.
REQ-011 SHALL have port o_win_valid  output  1  winner offered.
REQ-012 SHALL have port o_win_index  output  6  one-hot winner; bit k = neuron k.
REQ-013 SHALL have port o_win_value  output  p_width  winning potential.
REQ-014 SHALL have port o_no_winner  output  1  one-cycle pulse when a window produces no winner.
REQ-015 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, COLLECT, COMPARE, ISSUE, REFRACT.
REQ-017 IDLE: i_start=1 SHALL clear six potential registers and seen-mask to 0, load window counter p_window-1, enter COLLECT next cycle.
REQ-018 i_start outside IDLE SHALL be ignored (not queued).
REQ-019 COLLECT: each i_valid[k]=1 SHALL latch slice k and set seen[k]; repeated strobe overwrites (last wins); i_valid outside COLLECT ignored.
REQ-020 COLLECT SHALL exit to COMPARE when seen-mask (including this cycle's strobes) is all ones, or window counter is 0; counter decrements each COLLECT cycle.
REQ-021 COMPARE (exactly one cycle) SHALL select max of six registers, unsigned compare; tie SHALL resolve to lowest index (0 beats 1, pair{0,1} beats {2,3}, {0..3} beats {4,5}).
REQ-022 COMPARE SHALL declare no winner if all six registers are 0 or max < i_thresh; then pulse o_no_winner next cycle and return to IDLE.
REQ-023 Otherwise COMPARE SHALL register o_win_index/o_win_value and enter ISSUE.
REQ-024 ISSUE: o_win_valid=1; index/value SHALL stay stable until transfer (o_win_valid & i_win_ready).
REQ-025 Transfer SHALL drop o_win_valid next cycle and enter REFRACT with counter p_refr-1, or IDLE if p_refr=0.
REQ-026 REFRACT SHALL last exactly p_refr cycles, then IDLE; o_win_index/o_win_value SHALL return to 0 on leaving ISSUE.
REQ-027 Latency: i_start at edge N -> COLLECT from N+1; all-six-valid at edge M -> COMPARE at M+1 -> o_win_valid at M+2.
REQ-028 o_no_winner and o_win_valid SHALL never be high in the same cycle.

Reset
REQ-029 i_rst_n=0 SHALL immediately force IDLE, all outputs 0, potential registers, seen-mask and counters 0, regardless of state (including mid-ISSUE with o_win_valid high).
REQ-030 First i_start after reset release SHALL behave as REQ-017.

Verification
REQ-031 Start; strobe all six in one cycle with pots {5,9,3,9,1,2}, thresh 4 -> o_win_index=000010, value 9, o_win_valid two cycles after strobe.
REQ-032 Start; strobe only k=4 pot 7, thresh 0, p_window=16 -> COMPARE after 16 COLLECT cycles, index 010000, value 7.
REQ-033 Start; pots max 3, thresh 4 -> one-cycle o_no_winner, no o_win_valid, o_busy low next cycle.
REQ-034 Hold i_win_ready=0 for 5 cycles in ISSUE -> index/value stable; ready=1 -> REFRACT 8 cycles; i_start during REFRACT ignored.
REQ-035 Assert i_rst_n=0 mid-ISSUE -> o_win_valid, o_busy, o_win_index, o_win_value 0 without clock edge.
